// File: rtl/cordic_iter_engine_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cordic_pkg : shared types and elaboration-time constants for the CORDIC engine
// Rev 1.0
// ----------------------------------------------------------------------------
package cordic_pkg;

   typedef enum logic {
      ROTATE = 1'b0,
      VECTOR = 1'b1
   } mode_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_ITER  = 3'd2,
      S_SCALE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam real c_PI_R = 3.14159265358979323846;

   function automatic real pow2_r(input int n);
      real r;
      r = 1.0;
      for (int i = 0; i < n; i++) r = r * 2.0;
      return r;
   endfunction

   // All callers pass non-negative values, so add-half-and-truncate is round-to-nearest.
   function automatic int round_pos(input real r);
      return $rtoi(r + 0.5);
   endfunction

   function automatic real sqrt_r(input real a);
      real g;
      g = a;
      for (int i = 0; i < 40; i++) g = 0.5 * (g + a / g);
      return g;
   endfunction

   // Series is only used for t <= 0.5, where 24 terms are far below one LSB.
   function automatic real atan_r(input int idx);
      real t, t2, term, acc;
      if (idx == 0) return c_PI_R / 4.0;
      t    = 1.0 / pow2_r(idx);
      t2   = t * t;
      term = t;
      acc  = 0.0;
      for (int n = 0; n < 24; n++) begin
         if ((n % 2) == 0) acc = acc + term / real'(2 * n + 1);
         else              acc = acc - term / real'(2 * n + 1);
         term = term * t2;
      end
      return acc;
   endfunction

   function automatic int pi_q(input int angle_w);
      return round_pos(c_PI_R * pow2_r(angle_w - 3));
   endfunction

   function automatic int half_pi_q(input int angle_w);
      return round_pos(c_PI_R * 0.5 * pow2_r(angle_w - 3));
   endfunction

   function automatic int atan_q(input int idx, input int angle_w);
      return round_pos(atan_r(idx) * pow2_r(angle_w - 3));
   endfunction

   function automatic int kinv_q(input int iter, input int frac_w);
      real p;
      p = 1.0;
      for (int i = 0; i < iter; i++) p = p * (1.0 + 1.0 / pow2_r(2 * i));
      return round_pos(pow2_r(frac_w) / sqrt_r(p));
   endfunction

   function automatic int idx_w(input int iter);
      return (iter > 1) ? $clog2(iter) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_iter_engine_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cordic_iter_engine_if : operand/result handshake bundle of the CORDIC engine
// Rev 1.0
// ----------------------------------------------------------------------------
interface cordic_iter_engine_if
   import cordic_pkg::*;
#(
   parameter int WIDTH   = 14,
   parameter int ANGLE_W = 17
) ();
   logic                      in_valid;
   logic                      in_ready;
   mode_t                     in_mode;
   logic signed [WIDTH-1:0]   in_x;
   logic signed [WIDTH-1:0]   in_y;
   logic signed [ANGLE_W-1:0] in_z;
   logic                      out_valid;
   logic                      out_ready;
   logic signed [WIDTH-1:0]   out_x;
   logic signed [WIDTH-1:0]   out_y;
   logic signed [ANGLE_W-1:0] out_z;
   logic                      busy;

   modport master (
      output in_valid, in_mode, in_x, in_y, in_z, out_ready,
      input  in_ready, out_valid, out_x, out_y, out_z, busy
   );

   modport slave (
      input  in_valid, in_mode, in_x, in_y, in_z, out_ready,
      output in_ready, out_valid, out_x, out_y, out_z, busy
   );
endinterface
`default_nettype wire

// File: rtl/cordic_iter_engine_atan_rom.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cordic_atan_rom : combinational atan(2^-i) table in Q3.(ANGLE_W-3) radians
// Rev 1.0
// ----------------------------------------------------------------------------
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int ANGLE_W = 17,
   parameter int ITER    = 14,
   parameter int IDX_W   = idx_w(ITER)
) (
   input  logic [IDX_W-1:0]          i_idx,
   output logic signed [ANGLE_W-1:0] o_atan
);
   logic signed [ANGLE_W-1:0] w_tab [ITER];

   for (genvar g = 0; g < ITER; g++) begin : g_tab
      localparam logic signed [ANGLE_W-1:0] c_ATAN = ANGLE_W'(atan_q(g, ANGLE_W));
      assign w_tab[g] = c_ATAN;
   end

   always_comb begin
      o_atan = '0;
      if (32'(i_idx) < ITER) o_atan = w_tab[i_idx];
   end
endmodule
`default_nettype wire

// File: rtl/cordic_iter_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cordic_iter_engine : iterative rotation/vectoring CORDIC with quadrant fold
// Rev 1.0
// ----------------------------------------------------------------------------
module cordic_iter_engine
   import cordic_pkg::*;
#(
   parameter int WIDTH     = 14,
   parameter int ANGLE_W   = 17,
   parameter int ITER      = 14,
   parameter int GAIN_COMP = 1
) (
   input  logic                clk,
   input  logic                rst,
   cordic_iter_engine_if.slave bus
);
   localparam int XW    = WIDTH + 2;
   localparam int PW    = 2 * XW + 1;
   localparam int IDX_W = idx_w(ITER);

   localparam logic signed [ANGLE_W-1:0] c_HALF_PI     = ANGLE_W'(half_pi_q(ANGLE_W));
   localparam logic signed [ANGLE_W-1:0] c_NEG_HALF_PI = -c_HALF_PI;
   localparam logic signed [XW:0]        c_KINV        = (XW + 1)'(kinv_q(ITER, XW));
   localparam logic signed [PW-1:0]      c_RND         = PW'(1 << (XW - 1));
   localparam logic signed [XW:0]        c_SMAX        = (XW + 1)'((1 << (WIDTH - 1)) - 1);
   localparam logic signed [XW:0]        c_SMIN        = (XW + 1)'(-(1 << (WIDTH - 1)));

   state_t                    r_state;
   state_t                    w_state_nxt;
   mode_t                     r_mode;
   logic signed [XW-1:0]      r_x;
   logic signed [XW-1:0]      r_y;
   logic signed [ANGLE_W-1:0] r_z;
   logic [IDX_W-1:0]          r_iter;
   logic signed [WIDTH-1:0]   r_out_x;
   logic signed [WIDTH-1:0]   r_out_y;
   logic signed [ANGLE_W-1:0] r_out_z;

   logic signed [XW-1:0]      w_xs;
   logic signed [XW-1:0]      w_ys;
   logic signed [ANGLE_W-1:0] w_atan;
   logic                      w_last;
   logic                      w_d_pos;
   logic signed [XW:0]        w_sx;
   logic signed [XW:0]        w_sy;

   cordic_atan_rom #(
      .ANGLE_W (ANGLE_W),
      .ITER    (ITER),
      .IDX_W   (IDX_W)
   ) u_atan_rom (
      .i_idx  (r_iter),
      .o_atan (w_atan)
   );

   assign w_xs    = r_x >>> r_iter;
   assign w_ys    = r_y >>> r_iter;
   assign w_last  = (r_iter == IDX_W'(ITER - 1));
   assign w_d_pos = (r_mode == ROTATE) ? ~r_z[ANGLE_W-1] : r_y[XW-1];

   // Gain stage: product plus half-LSB, then floor back to the guard-bit width.
   if (GAIN_COMP != 0) begin : g_comp
      assign w_sx = (XW + 1)'((PW'(r_x) * PW'(c_KINV) + c_RND) >>> XW);
      assign w_sy = (XW + 1)'((PW'(r_y) * PW'(c_KINV) + c_RND) >>> XW);
   end else begin : g_raw
      assign w_sx = (XW + 1)'(r_x);
      assign w_sy = (XW + 1)'(r_y);
   end

   function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [XW:0] v);
      if (v > c_SMAX)      return c_SMAX[WIDTH-1:0];
      else if (v < c_SMIN) return c_SMIN[WIDTH-1:0];
      else                 return v[WIDTH-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.in_valid)  w_state_nxt = S_PRE;
         S_PRE:                      w_state_nxt = S_ITER;
         S_ITER:  if (w_last)        w_state_nxt = S_SCALE;
         S_SCALE:                    w_state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
         default:                    w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode  <= ROTATE;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_iter  <= '0;
         r_out_x <= '0;
         r_out_y <= '0;
         r_out_z <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_mode <= bus.in_mode;
                  r_x    <= XW'(bus.in_x);
                  r_y    <= XW'(bus.in_y);
                  r_z    <= bus.in_z;
                  r_iter <= '0;
               end
            end
            S_PRE: begin
               // Fold by +/-90 degrees so the residual lies inside the CORDIC convergence range.
               if (r_mode == ROTATE) begin
                  if (r_z > c_HALF_PI) begin
                     r_x <= -r_y;
                     r_y <= r_x;
                     r_z <= r_z - c_HALF_PI;
                  end else if (r_z < c_NEG_HALF_PI) begin
                     r_x <= r_y;
                     r_y <= -r_x;
                     r_z <= r_z + c_HALF_PI;
                  end
               end else if (r_x[XW-1]) begin
                  if (!r_y[XW-1]) begin
                     r_x <= r_y;
                     r_y <= -r_x;
                     r_z <= r_z + c_HALF_PI;
                  end else begin
                     r_x <= -r_y;
                     r_y <= r_x;
                     r_z <= r_z - c_HALF_PI;
                  end
               end
               r_iter <= '0;
            end
            S_ITER: begin
               if (w_d_pos) begin
                  r_x <= r_x - w_ys;
                  r_y <= r_y + w_xs;
                  r_z <= r_z - w_atan;
               end else begin
                  r_x <= r_x + w_ys;
                  r_y <= r_y - w_xs;
                  r_z <= r_z + w_atan;
               end
               r_iter <= r_iter + 1'b1;
            end
            S_SCALE: begin
               r_out_x <= sat_w(w_sx);
               r_out_y <= sat_w(w_sy);
               r_out_z <= r_z;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE) && !rst;
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.out_x     = r_out_x;
   assign bus.out_y     = r_out_y;
   assign bus.out_z     = r_out_z;
endmodule
`default_nettype wire

// File: tb/tb_cordic_iter_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cordic_iter_engine : directed-vector bench for cordic_iter_engine
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cordic_iter_engine;
   import cordic_pkg::*;

   localparam int WIDTH   = 14;
   localparam int ANGLE_W = 17;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   cordic_iter_engine_if #(.WIDTH(WIDTH), .ANGLE_W(ANGLE_W)) bus ();

   cordic_iter_engine #(
      .WIDTH     (WIDTH),
      .ANGLE_W   (ANGLE_W),
      .ITER      (14),
      .GAIN_COMP (1)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp, input int tol);
      int diff;
      n_checks++;
      diff = got - exp;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, got, exp, tol);
      end
   endtask

   task automatic start_op(input mode_t m, input int x, input int y, input int z);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("in_ready_wait", int'(bus.in_ready), 1, 0);
      bus.in_mode  = m;
      bus.in_x     = WIDTH'(x);
      bus.in_y     = WIDTH'(y);
      bus.in_z     = ANGLE_W'(z);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic take();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int az;
      bus.in_valid  = 1'b0;
      bus.in_mode   = ROTATE;
      bus.in_x      = '0;
      bus.in_y      = '0;
      bus.in_z      = '0;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  int'(bus.in_ready), 0, 0);
      check("rst_out_valid", int'(bus.out_valid), 0, 0);
      check("rst_busy",      int'(bus.busy), 0, 0);
      check("rst_out_x",     int'(bus.out_x), 0, 0);
      check("rst_out_y",     int'(bus.out_y), 0, 0);
      check("rst_out_z",     int'(bus.out_z), 0, 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", int'(bus.in_ready), 1, 0);

      // Rotation of 0.5 by 120 degrees, exercising the z > pi/2 fold.
      start_op(ROTATE, 2048, 0, 34315);
      check("rot120_busy", int'(bus.busy), 1, 0);
      wait_result(lat);
      check("rot120_lat", lat, 16, 0);
      check("rot120_x", int'(bus.out_x), -1024, 4);
      check("rot120_y", int'(bus.out_y), 1774, 4);
      check("rot120_z", int'(bus.out_z), 0, 8);
      take();
      check("rot120_ready", int'(bus.in_ready), 1, 0);

      start_op(VECTOR, 4096, 4096, 0);
      wait_result(lat);
      check("vec45_lat", lat, 16, 0);
      check("vec45_x", int'(bus.out_x), 5793, 4);
      check("vec45_y", int'(bus.out_y), 0, 4);
      check("vec45_z", int'(bus.out_z), 12868, 4);
      take();

      start_op(VECTOR, -4096, 0, 0);
      wait_result(lat);
      check("vec180_x", int'(bus.out_x), 4096, 4);
      check("vec180_y", int'(bus.out_y), 0, 4);
      az = int'(bus.out_z);
      if (az < 0) az = -az;
      check("vec180_absz", az, 51472, 4);
      take();

      start_op(ROTATE, 8191, 8191, 12868);
      wait_result(lat);
      check("sat_y", int'(bus.out_y), 8191, 0);
      check("sat_x", int'(bus.out_x), 0, 4);
      take();

      // Backpressure: result must hold while a competing request is presented.
      start_op(ROTATE, 4096, 0, 12868);
      wait_result(lat);
      for (int c = 0; c < 10; c++) begin
         if (c == 2) begin
            bus.in_valid = 1'b1;
            bus.in_mode  = VECTOR;
            bus.in_x     = WIDTH'(-3000);
            bus.in_y     = WIDTH'(1000);
            bus.in_z     = ANGLE_W'(0);
         end
         @(posedge clk); #1;
         check("bp_valid", int'(bus.out_valid), 1, 0);
         check("bp_ready", int'(bus.in_ready), 0, 0);
         check("bp_x", int'(bus.out_x), 2896, 4);
         check("bp_y", int'(bus.out_y), 2896, 4);
         check("bp_z", int'(bus.out_z), 0, 8);
      end
      bus.in_valid = 1'b0;
      take();
      check("bp_ready_after", int'(bus.in_ready), 1, 0);
      check("bp_valid_after", int'(bus.out_valid), 0, 0);
      @(posedge clk); #1;
      check("bp_busy_after", int'(bus.busy), 0, 0);

      start_op(ROTATE, 4096, 4096, 6000);
      repeat (6) @(posedge clk);
      #1;
      check("mid_busy", int'(bus.busy), 1, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mrst_valid", int'(bus.out_valid), 0, 0);
      check("mrst_busy",  int'(bus.busy), 0, 0);
      check("mrst_x",     int'(bus.out_x), 0, 0);
      check("mrst_y",     int'(bus.out_y), 0, 0);
      check("mrst_z",     int'(bus.out_z), 0, 0);

      start_op(ROTATE, 4096, 0, 0);
      wait_result(lat);
      check("rot0_lat", lat, 16, 0);
      check("rot0_x", int'(bus.out_x), 4096, 4);
      check("rot0_y", int'(bus.out_y), 0, 4);
      check("rot0_z", int'(bus.out_z), 0, 8);
      take();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish before 500000 ns");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire

// File: doc/cordic_iter_engine.md
# cordic_iter_engine

Parametrised iterative CORDIC engine; successor to the fixed-width rotation-only core. Supports rotation mode (sin/cos, vector rotate) and vectoring mode (magnitude/phase) over the full ±π angle range, with quadrant pre-rotation, optional gain compensation, output saturation and valid/ready handshakes on both sides. It sits between the sample-control logic and downstream mixers/phase detectors in the DSP datapath.

## Interface
- WIDTH, 14: signed x/y width, format Q2.(WIDTH-2)
- ANGLE_W, 17: signed angle width, format Q3.(ANGLE_W-3) radians
- ITER, 14: CORDIC iterations, 1..ANGLE_W-3
- GAIN_COMP, 1: 1 = multiply results by K⁻¹ ≈ 0.607253; 0 = raw gain ≈ 1.6468
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input operands valid
- in_ready  out  1  engine can accept (idle)
- in_mode  in  1  0 = rotation, 1 = vectoring
- in_x, in_y  in  WIDTH  signed operands
- in_z  in  ANGLE_W  signed angle (rotation target, or vectoring initial phase)
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  downstream accepts result
- out_x, out_y  out  WIDTH  signed results, saturated
- out_z  out  ANGLE_W  residual angle (rotation) or accumulated phase (vectoring)
- busy  out  1  high in any state except IDLE

## Operation
- FSM: IDLE → PRE → ITER → SCALE → DONE → IDLE.
- IDLE: in_ready = 1 (forced 0 while rst high). On in_valid && in_ready, register mode/x/y/z, sign-extend x/y to WIDTH+2 guard bits, go to PRE.
- PRE (quadrant fold, 1 cycle):
  - Rotation, z > π/2: (x,y,z) ← (−y, x, z−π/2).
  - Rotation, z < −π/2: (x,y,z) ← (y, −x, z+π/2).
  - Vectoring, x < 0, y ≥ 0: (x,y,z) ← (y, −x, z+π/2).
  - Vectoring, x < 0, y < 0: (x,y,z) ← (−y, x, z−π/2).
  - Otherwise unchanged.
- ITER, i = 0..ITER-1, one iteration per cycle:
  - d = +1 if (rotation and z ≥ 0) or (vectoring and y < 0), else −1.
  - x ← x − d·(y >>> i); y ← y + d·(x >>> i); z ← z − d·atan(2⁻ⁱ).
  - Shifts are arithmetic. atan values are ROM constants in Q3.(ANGLE_W-3), rounded to nearest.
- SCALE (1 cycle):
  - GAIN_COMP = 1: x,y × K⁻¹, with K⁻¹ a WIDTH+2-bit unsigned fraction, rounded half-up.
  - GAIN_COMP = 0: pass-through.
  - Saturate x,y to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
  - z wraps modulo 2^ANGLE_W; no saturation. π·2^(ANGLE_W-3) < 2^(ANGLE_W-1).
- DONE: out_valid = 1; outputs stable. On out_ready, go to IDLE.
- Reset at any point: state IDLE; out_valid, busy, out_x, out_y, out_z = 0; in-flight operation discarded.
- Reset values: in_ready 0 during rst, 1 on the first cycle after; every other output 0.

## Timing
- Accepting edge E0. PRE executes on E1. Iterations execute on E2..E(ITER+1). SCALE executes on E(ITER+2).
- out_valid is high after E(ITER+2), i.e. ITER+2 edges after acceptance (16 cycles at ITER = 14).
- in_ready falls after E0 and rises the cycle after the out_valid && out_ready edge. No overlap between operations.
- Minimum initiation interval: ITER+4 cycles with out_ready held high.
- in_* are ignored when in_ready = 0.
- out_ready asserted before out_valid has no effect.

## Structure
- Package cordic_pkg:
  - Mode enum (ROTATE, VECTOR).
  - FSM state enum.
  - Constant functions: PI and HALF_PI scaled to ANGLE_W; K⁻¹ scaled to WIDTH+2.
  - atan(2⁻ⁱ) table generator, computed at elaboration from real arithmetic and rounded.
- Sub-module cordic_atan_rom: combinational, indexed by iteration count, parameterised by ANGLE_W and ITER.
- Top module: FSM, iteration counter, x/y/z datapath registers, scale multiplier and saturation.

## Test plan
All scenarios use defaults: WIDTH = 14, ANGLE_W = 17, ITER = 14, GAIN_COMP = 1. Tolerance ±4 LSB unless stated.
- Rotation, x = 2048 (0.5), y = 0, z = 34315 (≈120°) → out_x ≈ −1024, out_y ≈ 1774, out_z ≈ 0 (±8); out_valid exactly 16 cycles after acceptance.
- Vectoring, x = 4096, y = 4096, z = 0 → out_x ≈ 5793 (√2), out_y ≈ 0, out_z ≈ 12868 (π/4).
- Vectoring, x = −4096, y = 0, z = 0 (pre-rotation path) → out_x ≈ 4096, out_z ≈ ±51472 (±π).
- Saturation, rotation, x = y = 8191, z = 12868 → out_y = 8191 (saturated), out_x ≈ 0.
- Backpressure: out_ready held low for 10 cycles after out_valid → out_valid and out_* stable, in_ready = 0, a second in_valid is ignored; after the handshake, in_ready rises on the next cycle.
- Reset pulsed mid-ITER → next cycle out_valid = 0, busy = 0, out_* = 0; a new operation afterwards (rotation, x = 4096, y = 0, z = 0) returns out_x ≈ 4096, out_y ≈ 0.
